// File: rtl/adc_stream_ctrl_if.sv
// Frame-path bundle between the frame packer / push sequencer and the
// ADC stream run controller. The controller side uses the master modport,
// the surrounding environment (packer, FIFO level, sequencer) the slave one.
interface adc_stream_ctrl_if #(
  parameter int unsigned LVL_W = 8
);
  logic             adc_frame_valid;  // packer: frame complete (1-cycle pulse)
  logic [LVL_W-1:0] fifo_free;        // downstream FIFO free word slots
  logic             pusher_busy;      // sequencer is draining a frame
  logic             fwd_frame_valid;  // to sequencer frame_valid (1-cycle pulse)

  modport master (
    input  adc_frame_valid,
    input  fifo_free,
    input  pusher_busy,
    output fwd_frame_valid
  );

  modport slave (
    output adc_frame_valid,
    output fifo_free,
    output pusher_busy,
    input  fwd_frame_valid
  );
endinterface

// File: rtl/adc_stream_ctrl.sv
// ADC stream run controller. Gates completed frames into the push
// sequencer only when a run is active, the sequencer is idle and the FIFO
// can hold a whole frame, so the FIFO never contains a partial frame.
// Also provides start/stop/frame-limit run control and saturating
// accepted/dropped counters with a sticky overrun flag.
module adc_stream_ctrl #(
  parameter int unsigned WORDS_OUT = 9,
  parameter int unsigned LVL_W     = 8,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  adc_stream_ctrl_if.master    bus_if,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_clear_counts,
  input  logic [CNT_W-1:0]     i_frame_limit,
  output logic                 o_running,
  output logic                 o_done,
  output logic                 o_overrun,
  output logic                 o_drop_pulse,
  output logic [CNT_W-1:0]     o_frames_accepted,
  output logic [CNT_W-1:0]     o_frames_dropped
);

  // Space check is done at a width that holds both operands zero-extended.
  localparam int unsigned CMP_W = ((LVL_W > 32) ? LVL_W : 32) + 1;
  localparam logic [CMP_W-1:0] C_WORDS_OUT = CMP_W'(WORDS_OUT);
  localparam logic [CNT_W-1:0] C_CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_limit;
  logic [CNT_W-1:0] r_run_cnt;
  logic             r_fwd;
  logic             r_drop;
  logic             r_running;
  logic             r_done;
  logic             r_overrun;
  logic [CNT_W-1:0] r_acc_cnt;
  logic [CNT_W-1:0] r_drp_cnt;

  logic             w_blocked;
  logic             w_space_ok;
  logic             w_frame_eval;
  logic             w_accept;
  logic             w_drop;
  logic [CNT_W-1:0] w_run_cnt_inc;
  logic             w_limit_hit;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == C_CNT_MAX) begin
      return v;
    end else begin
      return v + C_CNT_ONE;
    end
  endfunction

  // Frame decision: the registered forward pulse counts as busy to cover the
  // cycle before the sequencer raises its own busy.
  always_comb begin
    w_blocked     = bus_if.pusher_busy | r_fwd;
    w_space_ok    = (CMP_W'(bus_if.fifo_free) >= C_WORDS_OUT);
    w_frame_eval  = (r_state == ST_RUN) && bus_if.adc_frame_valid;
    w_accept      = w_frame_eval && !w_blocked && w_space_ok;
    w_drop        = w_frame_eval && !w_accept;
    w_run_cnt_inc = sat_inc(r_run_cnt);
    w_limit_hit   = w_accept && (r_limit != C_CNT_ZERO) && (w_run_cnt_inc == r_limit);
  end

  // Run-control FSM with registered pulses and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_limit   <= C_CNT_ZERO;
      r_run_cnt <= C_CNT_ZERO;
      r_fwd     <= 1'b0;
      r_drop    <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_fwd  <= w_accept;
      r_drop <= w_drop;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // stop in the same cycle overrides start
          if (i_start && !i_stop) begin
            r_state   <= ST_RUN;
            r_limit   <= i_frame_limit;
            r_run_cnt <= C_CNT_ZERO;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_run_cnt <= w_run_cnt_inc;
          end
          if (i_stop || w_limit_hit) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // wait out the forwarded pulse and the sequencer's drain
          if (!bus_if.pusher_busy && !r_fwd) begin
            r_state   <= ST_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  // Cumulative saturating counters and sticky overrun; clear beats any update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_cnt <= C_CNT_ZERO;
      r_drp_cnt <= C_CNT_ZERO;
      r_overrun <= 1'b0;
    end else if (i_clear_counts) begin
      r_acc_cnt <= C_CNT_ZERO;
      r_drp_cnt <= C_CNT_ZERO;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc_cnt <= sat_inc(r_acc_cnt);
      end
      if (w_drop) begin
        r_drp_cnt <= sat_inc(r_drp_cnt);
        r_overrun <= 1'b1;
      end
    end
  end

  assign bus_if.fwd_frame_valid = r_fwd;
  assign o_drop_pulse           = r_drop;
  assign o_running              = r_running;
  assign o_done                 = r_done;
  assign o_overrun              = r_overrun;
  assign o_frames_accepted      = r_acc_cnt;
  assign o_frames_dropped       = r_drp_cnt;

endmodule

// File: tb/tb_adc_stream_ctrl.sv
// Bench for adc_stream_ctrl: directed scenarios plus random traffic driven
// through a behavioural model; expected pulses and per-cycle status go into
// queues that an independent monitor drains and compares.
module tb_adc_stream_ctrl;
  localparam int CNT_W = 6;          // small so saturation is reachable
  localparam int WORDS = 9;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic start, stop, clr;
  logic [CNT_W-1:0] limit;
  logic running, done, overrun, drop_pulse;
  logic [CNT_W-1:0] frames_acc, frames_drp;

  always #5 clk = ~clk;

  adc_stream_ctrl_if #(.LVL_W(8)) bus_if ();

  adc_stream_ctrl #(.WORDS_OUT(WORDS), .LVL_W(8), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus_if            (bus_if.master),
    .i_start           (start),
    .i_stop            (stop),
    .i_clear_counts    (clr),
    .i_frame_limit     (limit),
    .o_running         (running),
    .o_done            (done),
    .o_overrun         (overrun),
    .o_drop_pulse      (drop_pulse),
    .o_frames_accepted (frames_acc),
    .o_frames_dropped  (frames_drp)
  );

  typedef struct { int cyc; bit fwd; } pulse_t;
  typedef struct { int cyc; bit running; bit done; bit ovr; int acc; int drp; } stat_t;

  pulse_t pq[$];
  stat_t  sq[$];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  // Model of the run: phase flags, per-run count, cumulative counters.
  bit m_run, m_drain, m_done, m_ovr, m_fwd;
  int m_lim, m_cnt, m_acc, m_drp;
  int seq_busy;   // fake sequencer: busy for a frame's worth of words

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Drive one cycle of inputs and advance the model to the post-edge view.
  task automatic drive(input bit r, input bit st, input bit sp, input bit cl,
                       input int lim, input bit fv, input int free, input bit bsy);
    bit busy, acc, drp;
    stat_t s;
    pulse_t p;
    @(negedge clk);
    busy = bsy || (seq_busy > 0);
    rst = r; start = st; stop = sp; clr = cl;
    limit = lim[CNT_W-1:0];
    bus_if.adc_frame_valid = fv;
    bus_if.fifo_free = free[7:0];
    bus_if.pusher_busy = busy;
    if (r) begin
      m_run = 0; m_drain = 0; m_done = 0; m_ovr = 0; m_fwd = 0;
      m_lim = 0; m_cnt = 0; m_acc = 0; m_drp = 0; seq_busy = 0;
    end else begin
      acc = m_run && fv && !(busy || m_fwd) && (free >= WORDS);
      drp = m_run && fv && !acc;
      if (cl) begin
        m_acc = 0; m_drp = 0; m_ovr = 0;
      end else begin
        if (acc) m_acc = sat(m_acc);
        if (drp) begin m_drp = sat(m_drp); m_ovr = 1; end
      end
      if (m_run) begin
        if (acc) m_cnt = sat(m_cnt);
        if (sp || (acc && m_lim != 0 && m_cnt == m_lim)) begin m_run = 0; m_drain = 1; end
      end else if (m_drain) begin
        if (!busy && !m_fwd) begin m_drain = 0; m_done = 1; end
      end else if (st && !sp) begin
        m_run = 1; m_done = 0; m_lim = lim; m_cnt = 0;
      end
      // sequencer goes busy the cycle after it sees frame_valid
      if (m_fwd) seq_busy = WORDS;
      else if (seq_busy > 0) seq_busy--;
      m_fwd = acc;
      if (acc || drp) begin p.cyc = cyc + 1; p.fwd = acc; pq.push_back(p); end
    end
    s.cyc = cyc + 1; s.running = m_run || m_drain; s.done = m_done; s.ovr = m_ovr;
    s.acc = m_acc; s.drp = m_drp;
    sq.push_back(s);
  endtask

  task automatic idle(input int n, input int free);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, free, 0);
  endtask

  task automatic frame(input int free, input bit bsy);
    drive(0, 0, 0, 0, 0, 1, free, bsy);
  endtask

  stat_t  mon_s;
  pulse_t mon_p;

  // Monitor: compare status every cycle and match each output pulse.
  always begin
    @(posedge clk);
    #1;
    if (sq.size() > 0) begin
      mon_s = sq.pop_front();
      chk("running", int'(running), int'(mon_s.running));
      chk("done", int'(done), int'(mon_s.done));
      chk("overrun", int'(overrun), int'(mon_s.ovr));
      chk("frames_accepted", int'(frames_acc), mon_s.acc);
      chk("frames_dropped", int'(frames_drp), mon_s.drp);
    end
    while (pq.size() > 0 && pq[0].cyc < cyc) begin
      n_vec++; n_err++;
      $display("FAIL pulse_missing cyc=%0d actual=none required=%s", pq[0].cyc,
               pq[0].fwd ? "fwd" : "drop");
      void'(pq.pop_front());
    end
    if (bus_if.fwd_frame_valid || drop_pulse) begin
      if (pq.size() == 0 || pq[0].cyc != cyc) begin
        n_vec++; n_err++;
        $display("FAIL pulse_unexpected cyc=%0d actual fwd=%0b drop=%0b required=none",
                 cyc, bus_if.fwd_frame_valid, drop_pulse);
      end else begin
        mon_p = pq.pop_front();
        chk("fwd_pulse", int'(bus_if.fwd_frame_valid), int'(mon_p.fwd));
        chk("drop_pulse", int'(drop_pulse), int'(!mon_p.fwd));
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0; limit = '0;
    bus_if.adc_frame_valid = 1'b0; bus_if.fifo_free = 8'd0; bus_if.pusher_busy = 1'b0;
    seq_busy = 0;
    repeat (3) drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 64);

    // unlimited run, three well-spaced frames
    drive(0, 1, 0, 0, 0, 0, 64, 0);
    for (int i = 0; i < 3; i++) begin frame(64, 0); idle(19, 64); end

    // space gating at the WORDS_OUT boundary
    frame(8, 0); idle(15, 64);
    frame(9, 0); idle(15, 64);

    // busy gating: back-to-back, then explicit busy
    frame(64, 0); frame(64, 0); idle(2, 0); frame(64, 1); idle(15, 64);

    // stop the run, drain to DONE
    drive(0, 0, 1, 0, 0, 0, 64, 0); idle(5, 64);

    // frame limit of 2 with four frames
    drive(0, 1, 0, 0, 2, 0, 64, 0);
    for (int i = 0; i < 4; i++) begin frame(64, 0); idle(14, 64); end

    // stop together with a frame, restart from DONE, start+stop in IDLE
    drive(0, 1, 0, 0, 0, 0, 64, 0); idle(3, 64);
    drive(0, 0, 1, 0, 0, 1, 64, 0); idle(15, 64);
    drive(0, 1, 0, 0, 0, 0, 64, 0); idle(3, 64);
    drive(0, 0, 1, 0, 0, 0, 64, 0); idle(3, 64);
    drive(1, 0, 0, 0, 0, 0, 64, 0);
    drive(0, 1, 1, 0, 0, 0, 64, 0); idle(3, 64);

    // saturation of the drop counter, then clear racing a drop
    drive(0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < CMAX + 6; i++) frame(0, 0);
    drive(0, 0, 0, 1, 0, 1, 0, 0);
    frame(0, 0); frame(0, 0);
    drive(0, 0, 1, 0, 0, 0, 64, 0); idle(5, 64);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(999) < 2), ($urandom_range(99) < 5), ($urandom_range(99) < 3),
            ($urandom_range(99) < 2), int'($urandom_range(4)), ($urandom_range(99) < 30),
            int'($urandom_range(20)), ($urandom_range(99) < 8));
    end
    drive(0, 0, 1, 0, 0, 0, 64, 0);
    idle(30, 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
